// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : hilo_muldiv_ctrl
// Brief   : E-stage HI/LO owner; sequences MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Revision: 1.0 - initial release
// =============================================================================
module hilo_muldiv_ctrl #(
    parameter int          MUL_LAT  = 2,
    parameter logic [63:0] HILO_RST = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic [63:0] hilo
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;
    localparam logic [5:0] c_mul_last = 6'(MUL_LAT - 1);
    localparam logic [5:0] c_div_last = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state, w_next;
    logic        r_busy;
    logic [63:0] r_hilo;
    logic [5:0]  r_cnt;
    logic [31:0] r_mag_a, r_mag_b;
    logic        r_sa, r_sb;
    logic [31:0] r_rem, r_quo;

    logic        w_stall;
    logic        w_is_md, w_is_mul, w_sgn_op, w_accept, w_mt;
    logic [31:0] w_abs_a, w_abs_b;
    logic [63:0] w_prod, w_prod_fix;
    logic [32:0] w_shift, w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nx, w_quo_nx, w_rem_fix, w_quo_fix, w_a_orig;
    logic [63:0] w_div_res;

    assign w_is_md  = (op >= c_op_mult) && (op <= c_op_divu);
    assign w_is_mul = (op == c_op_mult) || (op == c_op_multu);
    assign w_sgn_op = (op == c_op_mult) || (op == c_op_div);
    assign w_accept = (r_state == S_IDLE) && op_valid && w_is_md && !flush;
    assign w_mt     = (r_state == S_IDLE) && op_valid && !flush
                      && ((op == c_op_mthi) || (op == c_op_mtlo));

    // Operands are held as magnitudes; signs are only tracked for signed ops.
    assign w_abs_a = (w_sgn_op && a[31]) ? -a : a;
    assign w_abs_b = (w_sgn_op && b[31]) ? -b : b;

    assign w_prod     = {32'd0, r_mag_a} * {32'd0, r_mag_b};
    assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;

    // r_quo shifts dividend bits out of the top while quotient bits enter at the bottom.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_mag_b};
    assign w_qbit    = ~w_diff[32];
    assign w_rem_nx  = w_qbit ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nx  = {r_quo[30:0], w_qbit};
    assign w_quo_fix = (r_sa ^ r_sb) ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = r_sa ? -w_rem_nx : w_rem_nx;
    assign w_a_orig  = r_sa ? -r_mag_a : r_mag_a;
    assign w_div_res = (r_mag_b == 32'd0) ? {w_a_orig, 32'hFFFF_FFFF}
                                          : {w_rem_fix, w_quo_fix};

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    w_next  = w_is_mul ? S_MUL : S_DIV;
                    w_stall = 1'b1;
                end
                S_MUL: begin
                    w_stall = 1'b1;
                    if (r_cnt == c_mul_last) w_next = S_DONE;
                end
                S_DIV: begin
                    w_stall = 1'b1;
                    if (r_cnt == c_div_last) w_next = S_DONE;
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_hilo  <= HILO_RST;
            r_cnt   <= 6'd0;
            r_mag_a <= 32'd0;
            r_mag_b <= 32'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_MUL) || (w_next == S_DIV);
            if (!flush) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_cnt   <= 6'd0;
                            r_mag_a <= w_abs_a;
                            r_mag_b <= w_abs_b;
                            r_sa    <= w_sgn_op & a[31];
                            r_sb    <= w_sgn_op & b[31];
                            r_rem   <= 32'd0;
                            r_quo   <= w_abs_a;
                        end
                        if (w_mt) begin
                            if (op == c_op_mthi) r_hilo[63:32] <= a;
                            else                 r_hilo[31:0]  <= a;
                        end
                    end
                    S_MUL: begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_mul_last) r_hilo <= w_prod_fix;
                    end
                    S_DIV: begin
                        r_cnt <= r_cnt + 6'd1;
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        if (r_cnt == c_div_last) r_hilo <= w_div_res;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stall_req = w_stall;
    assign busy      = r_busy;
    assign hilo      = r_hilo;

endmodule
`default_nettype wire
